execution_stage: RTL and testbench
==================================

# execution_stage

Execute (EX) stage of the five-stage RV32I pipeline. Selects ALU operands from register data, PC and immediate, performs the ALU or branch-compare operation, and latches the result plus the forwarded memory/write-back control into the EX/MEM pipeline register. It sits between the decode stage and the data-cache (MEM) stage.

## Interface
- No parameters; data width fixed at 32, register address width 5.
- Clocking: one clock; reset is asynchronous and active-low.
- CLK  in  1  pipeline clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- STALL_EXECUTION_STAGE  in  1  1 = hold the EX/MEM register.
- PC_IN  in  32  PC of the instruction in EX.
- RD_ADDRESS_IN  in  5  destination register.
- RS1_DATA, RS2_DATA  in  32  source operands.
- IMM_DATA  in  32  sign-extended immediate.
- ALU_INSTRUCTION  in  5  operation code, see Operation.
- ALU_INPUT_1_SELECT  in  1  0 = RS1_DATA, 1 = PC_IN.
- ALU_INPUT_2_SELECT  in  1  0 = RS2_DATA, 1 = IMM_DATA.
- DATA_CACHE_LOAD_IN  in  3  load type, passed through.
- DATA_CACHE_STORE_IN  in  2  store type, passed through.
- WRITE_BACK_MUX_SELECT_IN  in  1  passed through.
- RD_WRITE_ENABLE_IN  in  1  passed through.
- RD_ADDRESS_OUT  out  5  registered RD_ADDRESS_IN.
- ALU_OUT  out  32  registered ALU result.
- BRANCH_TAKEN  out  1  registered branch/jump decision.
- DATA_CACHE_LOAD_OUT  out  3; DATA_CACHE_STORE_OUT  out  2  registered pass-through.
- DATA_CACHE_STORE_DATA  out  32  registered RS2_DATA.
- WRITE_BACK_MUX_SELECT_OUT, RD_WRITE_ENABLE_OUT  out  1  registered pass-through.

## Operation
- A = select1 ? PC_IN : RS1_DATA; B = select2 ? IMM_DATA : RS2_DATA.
- Opcodes (decimal): 0 NOP (result 0); 1 ADD A+B; 2 SUB A−B; 3 SLL A<<B[4:0]; 4 SLT signed A<B → 1/0; 5 SLTU unsigned; 6 XOR; 7 SRL logical A>>B[4:0]; 8 SRA arithmetic; 9 OR; 10 AND.
- Branches 11 BEQ, 12 BNE, 13 BLT, 14 BGE (signed), 15 BLTU, 16 BGEU (unsigned): always compare RS1_DATA vs RS2_DATA regardless of selects; BRANCH_TAKEN = compare result; ALU_OUT = 0.
- 17 PASS: result = B (LUI). 18 JUMP: result = A + 4 (link address, with select1 = 1), BRANCH_TAKEN = 1.
- Codes 19–31: result 0, BRANCH_TAKEN 0.
- BRANCH_TAKEN = 0 for all non-branch, non-jump codes.
- Arithmetic modulo 2^32, no overflow flags; shifts use only B[4:0].

## Timing
- All outputs registered: inputs sampled on rising CLK edge, visible after that edge; latency 1 cycle.
- STALL_EXECUTION_STAGE = 1 at an edge: every output register holds its value; inputs ignored.
- RST_N low: all outputs 0 immediately (asynchronous), independent of CLK; held 0 while low. Reset beats stall.
- First edge after RST_N deasserts loads normally (unless stalled).
- No handshake; bubble insertion is the decoder's job (drive NOP with RD_WRITE_ENABLE_IN = 0, store type 0).

## Structure
- Shared package: 5-bit ALU opcode constants (NOP…JUMP), data-width constant.
- One natural sub-module: alu (combinational: A, B, RS1, RS2, opcode → result, branch_taken). Top holds operand muxes and the EX/MEM register.

## Test plan
- RS1=2, RS2=1, selects 0, op ADD, one edge → ALU_OUT=3, BRANCH_TAKEN=0, DATA_CACHE_STORE_DATA=1.
- RS1=1, RS2=2, op SUB → ALU_OUT=0xFFFFFFFF; op SLT with RS1=0xFFFFFFFF, RS2=1 → 1, SLTU → 0.
- RS1=0x80000000, B=IMM=4, select2=1, op SRA → 0xF8000000; op SRL → 0x08000000.
- op BLT, RS1=−5, RS2=3 → BRANCH_TAKEN=1, ALU_OUT=0; BGEU same operands → 1; BEQ 7 vs 8 → 0.
- PC_IN=0x100, select1=1, op JUMP → ALU_OUT=0x104, BRANCH_TAKEN=1; then stall=1 with new inputs for 3 edges → outputs unchanged.
- Load nonzero outputs, drop RST_N between edges → all outputs 0 before next edge; release → next edge loads new inputs.

Source files
------------

// File: rtl/execution_stage_pkg.sv
// Shared constants for the RV32I execute stage: widths and ALU opcodes.
package execution_stage_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int OP_W       = 5;

  localparam logic [OP_W-1:0] OP_NOP  = 5'd0;
  localparam logic [OP_W-1:0] OP_ADD  = 5'd1;
  localparam logic [OP_W-1:0] OP_SUB  = 5'd2;
  localparam logic [OP_W-1:0] OP_SLL  = 5'd3;
  localparam logic [OP_W-1:0] OP_SLT  = 5'd4;
  localparam logic [OP_W-1:0] OP_SLTU = 5'd5;
  localparam logic [OP_W-1:0] OP_XOR  = 5'd6;
  localparam logic [OP_W-1:0] OP_SRL  = 5'd7;
  localparam logic [OP_W-1:0] OP_SRA  = 5'd8;
  localparam logic [OP_W-1:0] OP_OR   = 5'd9;
  localparam logic [OP_W-1:0] OP_AND  = 5'd10;
  localparam logic [OP_W-1:0] OP_BEQ  = 5'd11;
  localparam logic [OP_W-1:0] OP_BNE  = 5'd12;
  localparam logic [OP_W-1:0] OP_BLT  = 5'd13;
  localparam logic [OP_W-1:0] OP_BGE  = 5'd14;
  localparam logic [OP_W-1:0] OP_BLTU = 5'd15;
  localparam logic [OP_W-1:0] OP_BGEU = 5'd16;
  localparam logic [OP_W-1:0] OP_PASS = 5'd17;
  localparam logic [OP_W-1:0] OP_JUMP = 5'd18;

endpackage

// File: rtl/execution_stage_if.sv
// Decode-to-EX inputs and EX/MEM outputs of the execute stage.
interface execution_stage_if;
  import execution_stage_pkg::*;

  logic                  STALL_EXECUTION_STAGE;
  logic [DATA_W-1:0]     PC_IN;
  logic [REG_ADDR_W-1:0] RD_ADDRESS_IN;
  logic [DATA_W-1:0]     RS1_DATA;
  logic [DATA_W-1:0]     RS2_DATA;
  logic [DATA_W-1:0]     IMM_DATA;
  logic [OP_W-1:0]       ALU_INSTRUCTION;
  logic                  ALU_INPUT_1_SELECT;
  logic                  ALU_INPUT_2_SELECT;
  logic [2:0]            DATA_CACHE_LOAD_IN;
  logic [1:0]            DATA_CACHE_STORE_IN;
  logic                  WRITE_BACK_MUX_SELECT_IN;
  logic                  RD_WRITE_ENABLE_IN;

  logic [REG_ADDR_W-1:0] RD_ADDRESS_OUT;
  logic [DATA_W-1:0]     ALU_OUT;
  logic                  BRANCH_TAKEN;
  logic [2:0]            DATA_CACHE_LOAD_OUT;
  logic [1:0]            DATA_CACHE_STORE_OUT;
  logic [DATA_W-1:0]     DATA_CACHE_STORE_DATA;
  logic                  WRITE_BACK_MUX_SELECT_OUT;
  logic                  RD_WRITE_ENABLE_OUT;

  // Decode side: drives the instruction, observes the EX/MEM register.
  modport master (
    output STALL_EXECUTION_STAGE, PC_IN, RD_ADDRESS_IN, RS1_DATA, RS2_DATA, IMM_DATA,
           ALU_INSTRUCTION, ALU_INPUT_1_SELECT, ALU_INPUT_2_SELECT,
           DATA_CACHE_LOAD_IN, DATA_CACHE_STORE_IN, WRITE_BACK_MUX_SELECT_IN,
           RD_WRITE_ENABLE_IN,
    input  RD_ADDRESS_OUT, ALU_OUT, BRANCH_TAKEN, DATA_CACHE_LOAD_OUT,
           DATA_CACHE_STORE_OUT, DATA_CACHE_STORE_DATA, WRITE_BACK_MUX_SELECT_OUT,
           RD_WRITE_ENABLE_OUT
  );

  // Execute stage side.
  modport slave (
    input  STALL_EXECUTION_STAGE, PC_IN, RD_ADDRESS_IN, RS1_DATA, RS2_DATA, IMM_DATA,
           ALU_INSTRUCTION, ALU_INPUT_1_SELECT, ALU_INPUT_2_SELECT,
           DATA_CACHE_LOAD_IN, DATA_CACHE_STORE_IN, WRITE_BACK_MUX_SELECT_IN,
           RD_WRITE_ENABLE_IN,
    output RD_ADDRESS_OUT, ALU_OUT, BRANCH_TAKEN, DATA_CACHE_LOAD_OUT,
           DATA_CACHE_STORE_OUT, DATA_CACHE_STORE_DATA, WRITE_BACK_MUX_SELECT_OUT,
           RD_WRITE_ENABLE_OUT
  );

endinterface

// File: rtl/execution_stage_alu.sv
// Combinational RV32I ALU plus branch comparator.
module execution_stage_alu
  import execution_stage_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] rs1,
  input  logic [DATA_W-1:0] rs2,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] result,
  output logic              branch_taken
);

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic signed [DATA_W-1:0] rs1_s;
  logic signed [DATA_W-1:0] rs2_s;
  logic        [4:0]        shamt;

  assign a_s   = a;
  assign b_s   = b;
  assign rs1_s = rs1;
  assign rs2_s = rs2;
  assign shamt = b[4:0];

  // Branches always compare the raw register operands, independent of the operand muxes.
  always_comb begin
    result       = '0;
    branch_taken = 1'b0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_SLL:  result = a << shamt;
      OP_SLT:  result = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
      OP_XOR:  result = a ^ b;
      OP_SRL:  result = a >> shamt;
      OP_SRA:  result = a_s >>> shamt;
      OP_OR:   result = a | b;
      OP_AND:  result = a & b;
      OP_BEQ:  branch_taken = (rs1 == rs2);
      OP_BNE:  branch_taken = (rs1 != rs2);
      OP_BLT:  branch_taken = (rs1_s < rs2_s);
      OP_BGE:  branch_taken = (rs1_s >= rs2_s);
      OP_BLTU: branch_taken = (rs1 < rs2);
      OP_BGEU: branch_taken = (rs1 >= rs2);
      OP_PASS: result = b;
      OP_JUMP: begin
        result       = a + 32'd4;
        branch_taken = 1'b1;
      end
      default: begin
        result       = '0;
        branch_taken = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/execution_stage.sv
// RV32I execute stage: operand selection, ALU, and the EX/MEM pipeline register.
module execution_stage
  import execution_stage_pkg::*;
(
  input  logic               CLK,
  input  logic               RST_N,
  execution_stage_if.slave   ex
);

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_branch;

  logic [REG_ADDR_W-1:0] rd_address_p0;
  logic [DATA_W-1:0]     alu_out_p0;
  logic                  branch_taken_p0;
  logic [2:0]            load_p0;
  logic [1:0]            store_p0;
  logic [DATA_W-1:0]     store_data_p0;
  logic                  wb_sel_p0;
  logic                  rd_we_p0;

  assign op_a = ex.ALU_INPUT_1_SELECT ? ex.PC_IN    : ex.RS1_DATA;
  assign op_b = ex.ALU_INPUT_2_SELECT ? ex.IMM_DATA : ex.RS2_DATA;

  execution_stage_alu u_alu (
    .a            (op_a),
    .b            (op_b),
    .rs1          (ex.RS1_DATA),
    .rs2          (ex.RS2_DATA),
    .op           (ex.ALU_INSTRUCTION),
    .result       (alu_result),
    .branch_taken (alu_branch)
  );

  // ---- EX -> MEM boundary ----
  // EX/MEM register: cleared asynchronously, frozen while stalled (reset takes priority).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_address_p0   <= '0;
      alu_out_p0      <= '0;
      branch_taken_p0 <= 1'b0;
      load_p0         <= '0;
      store_p0        <= '0;
      store_data_p0   <= '0;
      wb_sel_p0       <= 1'b0;
      rd_we_p0        <= 1'b0;
    end else if (!ex.STALL_EXECUTION_STAGE) begin
      rd_address_p0   <= ex.RD_ADDRESS_IN;
      alu_out_p0      <= alu_result;
      branch_taken_p0 <= alu_branch;
      load_p0         <= ex.DATA_CACHE_LOAD_IN;
      store_p0        <= ex.DATA_CACHE_STORE_IN;
      store_data_p0   <= ex.RS2_DATA;
      wb_sel_p0       <= ex.WRITE_BACK_MUX_SELECT_IN;
      rd_we_p0        <= ex.RD_WRITE_ENABLE_IN;
    end
  end

  assign ex.RD_ADDRESS_OUT            = rd_address_p0;
  assign ex.ALU_OUT                   = alu_out_p0;
  assign ex.BRANCH_TAKEN              = branch_taken_p0;
  assign ex.DATA_CACHE_LOAD_OUT       = load_p0;
  assign ex.DATA_CACHE_STORE_OUT      = store_p0;
  assign ex.DATA_CACHE_STORE_DATA     = store_data_p0;
  assign ex.WRITE_BACK_MUX_SELECT_OUT = wb_sel_p0;
  assign ex.RD_WRITE_ENABLE_OUT       = rd_we_p0;

endmodule

// File: tb/tb_execution_stage.sv
// Randomized self-checking bench for execution_stage with a behavioural reference model.
module tb_execution_stage;

  logic CLK;
  logic RST_N;
  int   n_tests;
  int   n_fail;

  execution_stage_if bus ();

  execution_stage dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .ex    (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // expected EX/MEM contents
  logic [4:0]  e_rd;
  logic [31:0] e_alu;
  logic        e_br;
  logic [2:0]  e_ld;
  logic [1:0]  e_st;
  logic [31:0] e_sd;
  logic        e_wb;
  logic        e_we;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: the instruction semantics written directly with integer arithmetic.
  task automatic model(output logic [31:0] res, output logic br);
    logic [31:0] a, b, r1, r2, fill;
    int sh;
    a  = bus.ALU_INPUT_1_SELECT ? bus.PC_IN : bus.RS1_DATA;
    b  = bus.ALU_INPUT_2_SELECT ? bus.IMM_DATA : bus.RS2_DATA;
    r1 = bus.RS1_DATA;
    r2 = bus.RS2_DATA;
    sh = int'(b % 32);
    res = 32'd0;
    br  = 1'b0;
    case (int'(bus.ALU_INSTRUCTION))
      1:  res = a + b;
      2:  res = a + (~b + 32'd1);
      3:  res = a * (32'd1 << sh);
      4:  res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      5:  res = (longint'({32'd0, a}) < longint'({32'd0, b})) ? 32'd1 : 32'd0;
      6:  res = a ^ b;
      7:  res = a >> sh;
      8:  begin
            fill = (sh == 0) ? 32'd0 : ~(32'hFFFF_FFFF >> sh);
            res  = (a >> sh) | (a[31] ? fill : 32'd0);
          end
      9:  res = a | b;
      10: res = a & b;
      11: br = (r1 == r2);
      12: br = (r1 != r2);
      13: br = (int'(r1) <  int'(r2));
      14: br = (int'(r1) >= int'(r2));
      15: br = ({32'd0, r1} <  {32'd0, r2});
      16: br = ({32'd0, r1} >= {32'd0, r2});
      17: res = b;
      18: begin res = a + 32'd4; br = 1'b1; end
      default: begin res = 32'd0; br = 1'b0; end
    endcase
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rd"},  {27'd0, bus.RD_ADDRESS_OUT},            {27'd0, e_rd});
    check({tag, ".alu"}, bus.ALU_OUT,                            e_alu);
    check({tag, ".br"},  {31'd0, bus.BRANCH_TAKEN},              {31'd0, e_br});
    check({tag, ".ld"},  {29'd0, bus.DATA_CACHE_LOAD_OUT},       {29'd0, e_ld});
    check({tag, ".st"},  {30'd0, bus.DATA_CACHE_STORE_OUT},      {30'd0, e_st});
    check({tag, ".sd"},  bus.DATA_CACHE_STORE_DATA,              e_sd);
    check({tag, ".wb"},  {31'd0, bus.WRITE_BACK_MUX_SELECT_OUT}, {31'd0, e_wb});
    check({tag, ".we"},  {31'd0, bus.RD_WRITE_ENABLE_OUT},       {31'd0, e_we});
  endtask

  task automatic clear_exp();
    e_rd = '0; e_alu = '0; e_br = 1'b0; e_ld = '0;
    e_st = '0; e_sd = '0; e_wb = 1'b0; e_we = 1'b0;
  endtask

  // One clock edge: update the expected register from the current inputs, then compare.
  task automatic tick(input string tag);
    logic [31:0] r;
    logic        b;
    if (!bus.STALL_EXECUTION_STAGE) begin
      model(r, b);
      e_alu = r;
      e_br  = b;
      e_rd  = bus.RD_ADDRESS_IN;
      e_ld  = bus.DATA_CACHE_LOAD_IN;
      e_st  = bus.DATA_CACHE_STORE_IN;
      e_sd  = bus.RS2_DATA;
      e_wb  = bus.WRITE_BACK_MUX_SELECT_IN;
      e_we  = bus.RD_WRITE_ENABLE_IN;
    end
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [31:0] pc,
                       input logic s1, input logic s2);
    bus.ALU_INSTRUCTION    = op;
    bus.RS1_DATA           = rs1;
    bus.RS2_DATA           = rs2;
    bus.IMM_DATA           = imm;
    bus.PC_IN              = pc;
    bus.ALU_INPUT_1_SELECT = s1;
    bus.ALU_INPUT_2_SELECT = s2;
  endtask

  task automatic drive_side();
    bus.RD_ADDRESS_IN            = 5'($urandom_range(1, 31));
    bus.DATA_CACHE_LOAD_IN       = 3'($urandom);
    bus.DATA_CACHE_STORE_IN      = 2'($urandom);
    bus.WRITE_BACK_MUX_SELECT_IN = 1'($urandom);
    bus.RD_WRITE_ENABLE_IN       = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    RST_N   = 1'b0;
    bus.STALL_EXECUTION_STAGE = 1'b0;
    drive(5'd1, 32'd5, 32'd6, 32'd7, 32'd8, 1'b0, 1'b0);
    drive_side();
    clear_exp();
    repeat (2) @(posedge CLK);
    #1;
    check_all("reset");
    @(negedge CLK);
    RST_N = 1'b1;

    // directed cases
    drive_side();
    drive(5'd1, 32'd2, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0);
    tick("add");
    check("add.const", bus.ALU_OUT, 32'd3);
    check("add.sd_const", bus.DATA_CACHE_STORE_DATA, 32'd1);

    drive(5'd2, 32'd1, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0);
    tick("sub");
    check("sub.const", bus.ALU_OUT, 32'hFFFF_FFFF);
    drive(5'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0);
    tick("slt");
    check("slt.const", bus.ALU_OUT, 32'd1);
    drive(5'd5, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0);
    tick("sltu");
    check("sltu.const", bus.ALU_OUT, 32'd0);

    drive(5'd8, 32'h8000_0000, 32'd99, 32'd4, 32'd0, 1'b0, 1'b1);
    tick("sra");
    check("sra.const", bus.ALU_OUT, 32'hF800_0000);
    drive(5'd7, 32'h8000_0000, 32'd99, 32'd4, 32'd0, 1'b0, 1'b1);
    tick("srl");
    check("srl.const", bus.ALU_OUT, 32'h0800_0000);

    drive(5'd13, -32'sd5, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0);
    tick("blt");
    check("blt.const", {31'd0, bus.BRANCH_TAKEN}, 32'd1);
    check("blt.alu0", bus.ALU_OUT, 32'd0);
    drive(5'd16, -32'sd5, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0);
    tick("bgeu");
    check("bgeu.const", {31'd0, bus.BRANCH_TAKEN}, 32'd1);
    drive(5'd11, 32'd7, 32'd8, 32'd0, 32'd0, 1'b0, 1'b0);
    tick("beq");
    check("beq.const", {31'd0, bus.BRANCH_TAKEN}, 32'd0);

    drive(5'd18, 32'd55, 32'd66, 32'd0, 32'h100, 1'b1, 1'b0);
    tick("jump");
    check("jump.const", bus.ALU_OUT, 32'h104);
    check("jump.br", {31'd0, bus.BRANCH_TAKEN}, 32'd1);

    // stall holds everything for three edges
    bus.STALL_EXECUTION_STAGE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(5'($urandom), $urandom, $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom));
      drive_side();
      tick("stall");
    end
    check("stall.const", bus.ALU_OUT, 32'h104);
    bus.STALL_EXECUTION_STAGE = 1'b0;

    // asynchronous reset between edges, then reload
    drive(5'd9, 32'hF0F0_0000, 32'h0000_0F0F, 32'd0, 32'd0, 1'b0, 1'b0);
    tick("or");
    #2;
    RST_N = 1'b0;
    #1;
    clear_exp();
    check_all("async_rst");
    @(negedge CLK);
    check_all("rst_hold");
    bus.STALL_EXECUTION_STAGE = 1'b1;
    tick("rst_beats_stall");
    @(negedge CLK);
    RST_N = 1'b1;
    bus.STALL_EXECUTION_STAGE = 1'b0;
    drive(5'd17, 32'd0, 32'd0, 32'hABCD_E000, 32'd0, 1'b0, 1'b1);
    tick("pass_after_rst");

    // randomized sweep with occasional stalls and corner operands
    for (int i = 0; i < 400; i++) begin
      logic [31:0] r1, r2;
      @(negedge CLK);
      r1 = $urandom;
      r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
      if ($urandom_range(0, 7) == 0) r1 = 32'h8000_0000;
      drive(5'($urandom), r1, r2, $urandom, $urandom, 1'($urandom), 1'($urandom));
      drive_side();
      bus.STALL_EXECUTION_STAGE = ($urandom_range(0, 4) == 0);
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
